riscv_mem_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between the core's instruction-fetch port (dual-word fetch) and its data port (load/store with byte enables).
- Sits between riscv_core and a unified memory, replacing the separate instruction and data memories.
- Serialises each two-word fetch into two back-to-back SRAM reads.
- Arbitrates conflicting requests and returns a one-cycle ready pulse per completed transaction.

---
 rtl/riscv_mem_arbiter_if.sv | 38 +++
 rtl/riscv_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// rtl/riscv_mem_arbiter_if.sv - fetch, data and SRAM signal bundle for riscv_mem_arbiter
interface riscv_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [31:0]           if_data_0;
  logic [31:0]           if_data_1;
  logic                  if_ready;

  logic                  d_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_wen;
  logic [3:0]            d_byte_en;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ready;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_byte_en;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wdata, d_wen, d_byte_en, mem_rdata,
    output if_data_0, if_data_1, if_ready, d_rdata, d_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_byte_en
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_wdata, d_wen, d_byte_en, mem_rdata,
    input  if_data_0, if_data_1, if_ready, d_rdata, d_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one single-port SRAM between dual-word fetch and load/store ports
module riscv_mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input logic                clk,
  input logic                rst,
  riscv_mem_arbiter_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] IF_RD0 = 3'd1;
  localparam logic [2:0] IF_RD1 = 3'd2;
  localparam logic [2:0] IF_RSP = 3'd3;
  localparam logic [2:0] D_RD   = 3'd4;
  localparam logic [2:0] D_RSP  = 3'd5;
  localparam logic [2:0] D_WR   = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  logic [2:0]            state;
  logic                  last_grant_data;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            byte_en_q;
  logic                  if_ready_q;
  logic                  d_ready_q;
  logic [31:0]           if_data_0_q;
  logic [31:0]           if_data_1_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  logic                  if_eligible;
  logic                  d_eligible;
  logic                  grant_data;

  logic                  mem_en_c;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [3:0]            mem_byte_en_c;

  // A request still held during its own ready pulse is the one just served.
  assign if_eligible = bus.if_req && !if_ready_q;
  assign d_eligible  = bus.d_req && !d_ready_q;
  assign grant_data  = d_eligible && (!if_eligible || DATA_PRIORITY || !last_grant_data);

  always_comb begin
    mem_en_c      = 1'b0;
    mem_we_c      = 1'b0;
    mem_addr_c    = '0;
    mem_wdata_c   = '0;
    mem_byte_en_c = '0;
    case (state)
      IF_RD0, D_RD: begin
        mem_en_c   = 1'b1;
        mem_addr_c = base_addr;
      end
      IF_RD1: begin
        mem_en_c   = 1'b1;
        mem_addr_c = base_addr + WORD_STEP;
      end
      D_WR: begin
        mem_en_c      = 1'b1;
        mem_we_c      = 1'b1;
        mem_addr_c    = base_addr;
        mem_wdata_c   = wdata_q;
        mem_byte_en_c = byte_en_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant_data <= 1'b0;
      base_addr       <= '0;
      wdata_q         <= '0;
      byte_en_q       <= '0;
      if_ready_q      <= 1'b0;
      d_ready_q       <= 1'b0;
      if_data_0_q     <= '0;
      if_data_1_q     <= '0;
      d_rdata_q       <= '0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            base_addr       <= bus.d_addr & WORD_MASK;
            wdata_q         <= bus.d_wdata;
            byte_en_q       <= bus.d_byte_en;
            last_grant_data <= 1'b1;
            state           <= bus.d_wen ? D_WR : D_RD;
          end else if (if_eligible) begin
            base_addr       <= bus.if_addr & WORD_MASK;
            last_grant_data <= 1'b0;
            state           <= IF_RD0;
          end
        end
        IF_RD0: state <= IF_RD1;
        IF_RD1: begin
          if_data_0_q <= bus.mem_rdata[31:0];
          state       <= IF_RSP;
        end
        IF_RSP: begin
          if_data_1_q <= bus.mem_rdata[31:0];
          if_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        D_RD: state <= D_RSP;
        D_RSP: begin
          d_rdata_q <= bus.mem_rdata;
          d_ready_q <= 1'b1;
          state     <= IDLE;
        end
        D_WR: begin
          d_ready_q <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_data_0   = if_data_0_q;
  assign bus.if_data_1   = if_data_1_q;
  assign bus.if_ready    = if_ready_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.mem_en      = mem_en_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.mem_byte_en = mem_byte_en_c;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - bench for riscv_mem_arbiter, instance 0 data-priority, instance 1 round-robin
module tb_riscv_mem_arbiter;
  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wen;
    logic [3:0]  d_byte_en;
  } req_t;

  typedef struct packed {
    logic        if_ready;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] if_data_0;
    logic [31:0] if_data_1;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
  } rsp_t;

  typedef struct {
    bit        en, we, ifr, dr, dchk;
    bit [31:0] addr, wdata, if0, if1, dd;
    bit [3:0]  be;
  } exp_t;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  req_t        drv = '0;
  rsp_t        rs[2];
  logic [31:0] mrd[2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [31:0] sram [logic [32:0]];
  logic [31:0] shm  [logic [32:0]];
  exp_t        ex[2][DEPTH];
  int          free_at[2];
  bit          last_d[2];

  int          f_if[2], f_d[2];
  logic [31:0] v_if0[2], v_if1[2], v_d[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    riscv_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
    assign bus.if_req    = drv.if_req;
    assign bus.if_addr   = drv.if_addr;
    assign bus.d_req     = drv.d_req;
    assign bus.d_addr    = drv.d_addr;
    assign bus.d_wdata   = drv.d_wdata;
    assign bus.d_wen     = drv.d_wen;
    assign bus.d_byte_en = drv.d_byte_en;
    assign bus.mem_rdata = mrd[g];
    assign rs[g] = '{if_ready: bus.if_ready, d_ready: bus.d_ready, mem_en: bus.mem_en,
                     mem_we: bus.mem_we, if_data_0: bus.if_data_0, if_data_1: bus.if_data_1,
                     d_rdata: bus.d_rdata, mem_addr: bus.mem_addr, mem_wdata: bus.mem_wdata,
                     mem_byte_en: bus.mem_byte_en};
    riscv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(g == 0 ? 1'b1 : 1'b0)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_sram(input logic [32:0] key);
    return sram.exists(key) ? sram[key] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_shm(input logic [32:0] key);
    return shm.exists(key) ? shm[key] : 32'h0;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d got=%h expected=%h", nm, k, cyc, act, exp);
    end
  endtask

  // SRAM behaviour: synchronous read, byte-lane write
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rs[k].mem_en) begin
        if (rs[k].mem_we)
          sram[{k[0], rs[k].mem_addr}] = merge(rd_sram({k[0], rs[k].mem_addr}), rs[k].mem_wdata, rs[k].mem_byte_en);
        else
          mrd[k] <= rd_sram({k[0], rs[k].mem_addr});
      end
    end
  end

  // Transaction-level model: at each free arbitration slot pick a winner and schedule its SRAM cycles and ready pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int   s;
      bit   fi_el, d_el, take_d;
      logic [31:0] base;
      exp_t e;
      s = cyc % DEPTH;
      if (rst) begin
        for (int j = 0; j < 8; j++) ex[k][(cyc + j) % DEPTH] = '{default: '0};
        free_at[k] = cyc + 1;
        last_d[k]  = 1'b0;
        chk("rst_if_ready", k, 64'(rs[k].if_ready), 64'd0);
        chk("rst_d_ready",  k, 64'(rs[k].d_ready),  64'd0);
        chk("rst_mem_en",   k, 64'(rs[k].mem_en),   64'd0);
        chk("rst_mem_addr", k, 64'(rs[k].mem_addr), 64'd0);
      end else begin
        fi_el = drv.if_req && !ex[k][s].ifr;
        d_el  = drv.d_req && !ex[k][s].dr;
        if (cyc >= free_at[k] && (fi_el || d_el)) begin
          take_d    = d_el && (!fi_el || k == 0 || !last_d[k]);
          base      = (take_d ? drv.d_addr : drv.if_addr) & 32'hFFFF_FFFC;
          last_d[k] = take_d;
          ex[k][(cyc + 1) % DEPTH].en   = 1'b1;
          ex[k][(cyc + 1) % DEPTH].addr = base;
          if (!take_d) begin
            ex[k][(cyc + 2) % DEPTH].en   = 1'b1;
            ex[k][(cyc + 2) % DEPTH].addr = base + 32'd4;
            ex[k][(cyc + 4) % DEPTH].ifr  = 1'b1;
            ex[k][(cyc + 4) % DEPTH].if0  = rd_shm({k[0], base});
            ex[k][(cyc + 4) % DEPTH].if1  = rd_shm({k[0], base + 32'd4});
            free_at[k] = cyc + 4;
          end else if (drv.d_wen) begin
            ex[k][(cyc + 1) % DEPTH].we    = 1'b1;
            ex[k][(cyc + 1) % DEPTH].wdata = drv.d_wdata;
            ex[k][(cyc + 1) % DEPTH].be    = drv.d_byte_en;
            shm[{k[0], base}] = merge(rd_shm({k[0], base}), drv.d_wdata, drv.d_byte_en);
            ex[k][(cyc + 2) % DEPTH].dr = 1'b1;
            free_at[k] = cyc + 2;
          end else begin
            ex[k][(cyc + 3) % DEPTH].dr   = 1'b1;
            ex[k][(cyc + 3) % DEPTH].dchk = 1'b1;
            ex[k][(cyc + 3) % DEPTH].dd   = rd_shm({k[0], base});
            free_at[k] = cyc + 3;
          end
        end
        e = ex[k][s];
        chk("mem_en",      k, 64'(rs[k].mem_en),      64'(e.en));
        chk("mem_we",      k, 64'(rs[k].mem_we),      64'(e.we));
        chk("mem_addr",    k, 64'(rs[k].mem_addr),    64'(e.addr));
        chk("mem_wdata",   k, 64'(rs[k].mem_wdata),   64'(e.wdata));
        chk("mem_byte_en", k, 64'(rs[k].mem_byte_en), 64'(e.be));
        chk("if_ready",    k, 64'(rs[k].if_ready),    64'(e.ifr));
        chk("d_ready",     k, 64'(rs[k].d_ready),     64'(e.dr));
        if (e.ifr) begin
          chk("if_data_0", k, 64'(rs[k].if_data_0), 64'(e.if0));
          chk("if_data_1", k, 64'(rs[k].if_data_1), 64'(e.if1));
        end
        if (e.dchk) chk("d_rdata", k, 64'(rs[k].d_rdata), 64'(e.dd));
        ex[k][s] = '{default: '0};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    for (int k = 0; k < 2; k++) begin
      sram[{k[0], a}] = v;
      shm[{k[0], a}]  = v;
    end
  endtask

  // Holds the chosen requests for n cycles, noting the first ready pulse of each kind per instance.
  task automatic hold(input int n, input bit fi, input bit di);
    int t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      f_if[k] = -1;
      f_d[k]  = -1;
    end
    drv.if_req = fi;
    drv.d_req  = di;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (rs[k].if_ready && f_if[k] < 0) begin
          f_if[k]  = cyc - t0;
          v_if0[k] = rs[k].if_data_0;
          v_if1[k] = rs[k].if_data_1;
        end
        if (rs[k].d_ready && f_d[k] < 0) begin
          f_d[k] = cyc - t0;
          v_d[k] = rs[k].d_rdata;
        end
      end
      tick();
    end
    drv.if_req = 1'b0;
    drv.d_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    drv.if_req = 1'b0;
    drv.d_req  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_data(input logic [31:0] a, input bit wen, input logic [31:0] wd, input logic [3:0] be);
    drv.d_addr    = a;
    drv.d_wen     = wen;
    drv.d_wdata   = wd;
    drv.d_byte_en = be;
  endtask

  initial begin
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset_if_data_0", k, 64'(rs[k].if_data_0), 64'd0);
      chk("reset_d_rdata",   k, 64'(rs[k].d_rdata),   64'd0);
    end
    rst = 1'b0;
    tick();

    preload(32'h100, 32'hAAAA_0001);
    preload(32'h104, 32'hBBBB_0002);
    drv.if_addr = 32'h102;
    hold(5, 1'b1, 1'b0);
    chk("fetch_latency", 0, 64'(f_if[0]), 64'd4);
    chk("fetch_word0",   0, 64'(v_if0[0]), 64'hAAAA_0001);
    chk("fetch_word1",   0, 64'(v_if1[0]), 64'hBBBB_0002);
    idle(2);

    preload(32'h40, 32'hFFFF_FFFF);
    set_data(32'h40, 1'b1, 32'h1122_3344, 4'b0011);
    hold(3, 1'b0, 1'b1);
    chk("store_latency", 0, 64'(f_d[0]), 64'd2);
    set_data(32'h40, 1'b0, 32'h0, 4'b0000);
    hold(4, 1'b0, 1'b1);
    chk("load_latency", 0, 64'(f_d[0]), 64'd3);
    chk("load_merged",  0, 64'(v_d[0]), 64'hFFFF_3344);

    preload(32'h44, 32'h1234_5678);
    set_data(32'h46, 1'b1, 32'hDEAD_BEEF, 4'b0000);
    hold(3, 1'b0, 1'b1);
    chk("store_no_lanes_ready", 0, 64'(f_d[0]), 64'd2);
    set_data(32'h44, 1'b0, 32'h0, 4'b0000);
    hold(4, 1'b0, 1'b1);
    chk("store_no_lanes_kept", 0, 64'(v_d[0]), 64'h1234_5678);
    chk("load_retained_if0", 0, 64'(rs[0].if_data_0), 64'hAAAA_0001);

    preload(32'hFFFF_FFFC, 32'hCAFE_0000);
    preload(32'h0, 32'h0BAD_F00D);
    drv.if_addr = 32'hFFFF_FFFD;
    hold(5, 1'b1, 1'b0);
    chk("wrap_word0", 0, 64'(v_if0[0]), 64'hCAFE_0000);
    chk("wrap_word1", 0, 64'(v_if1[0]), 64'h0BAD_F00D);
    idle(2);

    drv.if_addr = 32'h100;
    set_data(32'h40, 1'b0, 32'h0, 4'b0000);
    hold(8, 1'b1, 1'b1);
    chk("prio_data_first", 0, 64'(f_d[0]), 64'd3);
    chk("prio_fetch_next", 0, 64'(f_if[0]), 64'd7);
    idle(8);

    hold(4, 1'b0, 1'b1);
    hold(5, 1'b1, 1'b1);
    chk("prio_after_load", 0, 64'(f_d[0]), 64'd3);
    chk("rr_after_load",   1, 64'(f_if[1]), 64'd4);
    idle(8);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold(16, 1'b1, 1'b1);
    chk("rr_first_data",  1, 64'(f_d[1]), 64'd3);
    chk("rr_second_fetch", 1, 64'(f_if[1]), 64'd7);
    idle(8);

    drv.if_addr = 32'h100;
    drv.if_req  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_rst_mem_en",    k, 64'(rs[k].mem_en),    64'd0);
      chk("async_rst_mem_addr",  k, 64'(rs[k].mem_addr),  64'd0);
      chk("async_rst_if_data_0", k, 64'(rs[k].if_data_0), 64'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    hold(5, 1'b1, 1'b0);
    chk("post_rst_fetch", 0, 64'(f_if[0]), 64'd4);
    chk("post_rst_word0", 0, 64'(v_if0[0]), 64'hAAAA_0001);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
